// File: rtl/prog_seq.sv
// -----------------------------------------------------------------------------
// prog_seq: program sequencer for the single-cycle core.
//
// Holds the program counter, runs a start/halt handshake (IDLE/RUN/DONE), and
// supports relative and absolute jumps plus a small hardware call/return stack.
// prog_ctr addresses instruction memory. The control inputs are decoded from
// the instruction at prog_ctr and take effect on the next rising edge. run
// gates architectural write-back in the consumer.
// -----------------------------------------------------------------------------
module prog_seq #(
    parameter  int PC_W        = 10,
    parameter  int STACK_DEPTH = 4,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,       // asynchronous, active-low
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic               halt,
    input  logic               jmp_en,
    input  logic               jmp_abs,
    input  logic [PC_W-1:0]    target,
    input  logic               call,
    input  logic               ret,
    output logic [PC_W-1:0]    prog_ctr,
    output logic               run,
    output logic               done,
    output logic               stack_err,
    output logic [DEPTH_W-1:0] depth
);

    // Width of a stack slot index. Keep it at least one bit so that a
    // single-entry stack still has a legal index.
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                err_q, err_d;

    // Return-address stack and its access signals.
    logic [PC_W-1:0]     stack_mem [STACK_DEPTH];
    logic                push_en;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;
    logic                stack_empty;
    logic                stack_full;

    // Shared PC arithmetic.
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     jump_tgt;

    // Derived datapath values: fall-through address, jump target, stack pointers.
    always_comb begin
        // A signed offset added in PC_W bits gives the same bits as the signed
        // sum reduced modulo 2^PC_W, so no sign extension is needed. Wrap-around
        // past the top of instruction space is intentional and silent.
        pc_inc      = pc_q + PC_W'(1);
        jump_tgt    = jmp_abs ? target : (pc_q + target);

        // depth counts valid entries. The next push therefore goes into slot
        // [depth] and the top of stack sits in slot [depth-1].
        push_idx    = IDX_W'(depth_q);
        top_idx     = IDX_W'(depth_q - DEPTH_W'(1));
        stack_empty = (depth_q == '0);
        stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    end

    // Next-state, next-PC and stack bookkeeping for the current instruction.
    always_comb begin
        // NOTE: every signal driven here is given a default first, so each path
        // through the case is fully specified and no latch can be inferred.
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Outside RUN, only start matters. Every other control input
                // is ignored and the architectural state holds.
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                    depth_d = '0;
                    err_d   = 1'b0;
                end
            end

            ST_RUN: begin
                // The order of this chain fixes the priority between
                // simultaneous controls. halt beats everything, and ret beats
                // call when both are set.
                if (halt) begin
                    state_d = ST_DONE;
                end else if (ret && !stack_empty) begin
                    pc_d    = stack_mem[top_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                end else if (ret) begin
                    // Underflow: stop with the PC parked on the offending ret.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (call && !stack_full) begin
                    push_en = 1'b1;
                    depth_d = depth_q + DEPTH_W'(1);
                    pc_d    = jump_tgt;
                end else if (call) begin
                    // Overflow: nothing is pushed and the PC stays on the call.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (jmp_en) begin
                    pc_d    = jump_tgt;
                end else begin
                    pc_d    = pc_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Architectural state register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its pre-edge value regardless of statement order.
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage, written on a successful call.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset. Entries at or above depth are
        // never read, and depth itself is reset, so clearing the storage would
        // only add reset fan-out.
        if (push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    // Outputs come straight from registers or from a decode of the state.
    assign prog_ctr  = pc_q;
    assign run       = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign stack_err = err_q;
    assign depth     = depth_q;

endmodule

// File: tb/tb_prog_seq.sv
// -----------------------------------------------------------------------------
// tb_prog_seq: self-checking bench for prog_seq.
// A directed vector table covers the documented scenarios. Hand-written
// sequences cover held start and asynchronous reset. A long random run is
// compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_prog_seq;

    localparam int PC_W   = 10;
    localparam int SD     = 4;
    localparam int DW     = $clog2(SD + 1);
    localparam int PC_MOD = 1 << PC_W;
    localparam int N_RAND = 3000;

    logic            clk        = 1'b0;
    logic            reset      = 1'b0;
    logic            start      = 1'b0;
    logic [PC_W-1:0] start_addr = '0;
    logic            halt       = 1'b0;
    logic            jmp_en     = 1'b0;
    logic            jmp_abs    = 1'b0;
    logic [PC_W-1:0] target     = '0;
    logic            call       = 1'b0;
    logic            ret        = 1'b0;
    logic [PC_W-1:0] prog_ctr;
    logic            run;
    logic            done;
    logic            stack_err;
    logic [DW-1:0]   depth;

    int n_checks = 0;
    int n_errors = 0;

    prog_seq #(.PC_W(PC_W), .STACK_DEPTH(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .halt       (halt),
        .jmp_en     (jmp_en),
        .jmp_abs    (jmp_abs),
        .target     (target),
        .call       (call),
        .ret        (ret),
        .prog_ctr   (prog_ctr),
        .run        (run),
        .done       (done),
        .stack_err  (stack_err),
        .depth      (depth)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vector record ----------------
    typedef struct {
        bit start;
        int start_addr;
        bit halt;
        bit jmp_en;
        bit jmp_abs;
        int target;
        bit call;
        bit ret;
        int e_pc;
        bit e_run;
        bit e_done;
        bit e_err;
        int e_depth;
    } vec_t;

    function automatic vec_t mk(input bit st, input int sa, input bit h, input bit j,
                                input bit ja, input int tg, input bit c, input bit r,
                                input int epc, input bit erun, input bit edone,
                                input bit eerr, input int edep);
        vec_t v;
        v.start = st;  v.start_addr = sa; v.halt = h;   v.jmp_en = j;
        v.jmp_abs = ja; v.target = tg;    v.call = c;   v.ret = r;
        v.e_pc = epc;  v.e_run = erun;    v.e_done = edone;
        v.e_err = eerr; v.e_depth = edep;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 = idle, 1 = running, 2 = finished. The stack is a plain queue
    // of return addresses with the newest entry at the back.
    int m_mode;
    int m_pc;
    bit m_err;
    int m_stack[$];

    function automatic int wrap(input int a);
        return ((a % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_err  = 0;
        m_stack.delete();
    endtask

    // Advance the model by one instruction using the inputs now driven.
    task automatic model_step();
        int off;
        int dest;
        off  = (int'(target) >= PC_MOD / 2) ? int'(target) - PC_MOD : int'(target);
        dest = jmp_abs ? int'(target) : wrap(m_pc + off);
        if (m_mode != 1) begin
            if (start) begin
                m_mode = 1;
                m_pc   = int'(start_addr);
                m_err  = 0;
                m_stack.delete();
            end
        end else if (halt) begin
            m_mode = 2;
        end else if (ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_err = 1; m_mode = 2; end
        end else if (call) begin
            if (m_stack.size() < SD) begin
                m_stack.push_back(wrap(m_pc + 1));
                m_pc = dest;
            end else begin
                m_err = 1; m_mode = 2;
            end
        end else if (jmp_en) begin
            m_pc = dest;
        end else begin
            m_pc = wrap(m_pc + 1);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        start      = v.start;
        start_addr = v.start_addr[PC_W-1:0];
        halt       = v.halt;
        jmp_en     = v.jmp_en;
        jmp_abs    = v.jmp_abs;
        target     = v.target[PC_W-1:0];
        call       = v.call;
        ret        = v.ret;
    endtask

    // One clock: update the model from the pre-edge inputs, then sample the
    // DUT 1 ns after the rising edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int pc, input bit r, input bit d,
                             input bit e, input int dep);
        check({tag, " prog_ctr"},  32'(prog_ctr),  pc);
        check({tag, " run"},       32'(run),       32'(r));
        check({tag, " done"},      32'(done),      32'(d));
        check({tag, " stack_err"}, 32'(stack_err), 32'(e));
        check({tag, " depth"},     32'(depth),     dep);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_pc, m_mode == 1, m_mode == 2, m_err, m_stack.size());
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[$];

    initial begin
        model_reset();

        // Reset state, with the reset held low and no edge required.
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors. Each row is one clock:
        // {start, addr, halt, jmp, abs, target, call, ret} -> {pc, run, done, err, depth}
        tbl.push_back(mk(1, 'h010, 0, 0, 0, 0,     0, 0, 'h010, 1, 0, 0, 0)); // start
        tbl.push_back(mk(0, 0,     0, 0, 0, 0,     0, 0, 'h011, 1, 0, 0, 0)); // step
        tbl.push_back(mk(0, 0,     0, 0, 0, 0,     0, 0, 'h012, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 1, 1, 'h020, 0, 0, 'h020, 1, 0, 0, 0)); // abs jump
        tbl.push_back(mk(0, 0,     0, 1, 0, 'h3FE, 0, 0, 'h01E, 1, 0, 0, 0)); // rel -2
        tbl.push_back(mk(0, 0,     0, 1, 1, 'h100, 0, 0, 'h100, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 1, 1, 'h3FF, 0, 0, 'h3FF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0, 0, 0,     0, 0, 'h000, 1, 0, 0, 0)); // wrap
        tbl.push_back(mk(0, 0,     0, 1, 1, 'h030, 0, 0, 'h030, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0, 1, 'h200, 1, 0, 'h200, 1, 0, 0, 1)); // call abs
        tbl.push_back(mk(0, 0,     0, 0, 0, 0,     0, 1, 'h031, 1, 0, 0, 0)); // ret
        tbl.push_back(mk(0, 0,     0, 0, 0, 'h005, 1, 0, 'h036, 1, 0, 0, 1)); // call rel
        tbl.push_back(mk(0, 0,     0, 0, 1, 'h300, 1, 1, 'h032, 1, 0, 0, 0)); // call+ret
        tbl.push_back(mk(1, 'h000, 0, 0, 0, 0,     0, 0, 'h033, 1, 0, 0, 0)); // start in RUN
        tbl.push_back(mk(0, 0,     0, 0, 0, 0,     0, 1, 'h033, 0, 1, 1, 0)); // underflow
        tbl.push_back(mk(0, 0,     0, 1, 1, 'h111, 1, 0, 'h033, 0, 1, 1, 0)); // ignored
        tbl.push_back(mk(1, 'h045, 0, 0, 0, 0,     0, 0, 'h045, 1, 0, 0, 0)); // restart
        tbl.push_back(mk(0, 0,     1, 1, 1, 'h123, 1, 0, 'h045, 0, 1, 0, 0)); // halt wins
        tbl.push_back(mk(0, 0,     0, 1, 1, 'h2AA, 1, 0, 'h045, 0, 1, 0, 0)); // ignored
        tbl.push_back(mk(1, 'h050, 0, 0, 0, 0,     0, 0, 'h050, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0, 0, 1,     1, 0, 'h051, 1, 0, 0, 1)); // nested calls
        tbl.push_back(mk(0, 0,     0, 0, 0, 1,     1, 0, 'h052, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0,     0, 0, 0, 1,     1, 0, 'h053, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0,     0, 0, 0, 1,     1, 0, 'h054, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0,     0, 0, 0, 1,     1, 0, 'h054, 0, 1, 1, 4)); // overflow

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            cycle();
            check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_run,
                      tbl[i].e_done, tbl[i].e_err, tbl[i].e_depth);
        end

        // Start held high: DONE -> RUN, then halt, then immediate re-entry.
        drive(mk(1, 'h070, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle();
        check_all("held start run", 'h070, 1, 0, 0, 0);
        halt = 1'b1;
        cycle();
        check_all("held start halt", 'h070, 0, 1, 0, 0);
        halt = 1'b0;
        cycle();
        check_all("held start rerun", 'h070, 1, 0, 0, 0);

        // Build some state, then pull reset mid-cycle with no edge.
        start   = 1'b0;
        call    = 1'b1;
        jmp_abs = 1'b0;
        target  = 10'd5;
        cycle();
        check_all("pre-reset call", 'h075, 1, 0, 0, 1);
        call = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all("reset held", 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;

        // Randomised run against the reference model.
        for (int i = 0; i < N_RAND; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            start_addr = PC_W'($urandom_range(0, PC_MOD - 1));
            halt       = ($urandom_range(0, 39) == 0);
            ret        = ($urandom_range(0, 5) == 0);
            call       = ($urandom_range(0, 4) == 0);
            jmp_en     = ($urandom_range(0, 3) == 0);
            jmp_abs    = ($urandom_range(0, 1) == 1);
            target     = ($urandom_range(0, 1) == 1) ? PC_W'($urandom_range(0, PC_MOD - 1))
                                                     : PC_W'($urandom_range(0, 7) - 4);
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
# prog_seq

Parametrised program sequencer: the next-generation program counter for the single-cycle core, adding a start/done run handshake, signed relative and absolute jumps, and a configurable-depth hardware call/return stack. It sits between `instr_ROM` and `control`. `prog_ctr` addresses instruction memory, and `run` gates register-file and data-memory writes. Control inputs are decoded from the instruction at the current `prog_ctr` and are sampled on the rising clock edge.

## Interface
- `PC_W`, 10: program-counter width in bits; instruction space is 2^PC_W words.
- `STACK_DEPTH`, 4: number of return-address entries; must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  begin execution; sampled only in IDLE or DONE.
- `start_addr`  in  PC_W  first instruction address, loaded on an accepted `start`.
- `halt`  in  1  current instruction is a halt.
- `jmp_en`  in  1  current instruction is a jump or branch that is taken.
- `jmp_abs`  in  1  1 = `target` is an absolute address; 0 = `target` is a signed two's-complement offset.
- `target`  in  PC_W  absolute address or signed offset.
- `call`  in  1  push the return address, then jump per `jmp_abs`/`target`.
- `ret`  in  1  pop the return address into the PC.
- `prog_ctr`  out  PC_W  address of the current instruction (registered).
- `run`  out  1  high while executing (state RUN).
- `done`  out  1  high in state DONE.
- `stack_err`  out  1  sticky error flag: a call overflowed or a return underflowed.
- `depth`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered or decoded directly from state.
- IDLE → RUN when `start`=1. On that edge:
  - `prog_ctr` ← `start_addr`
  - `depth` ← 0
  - `stack_err` ← 0
- DONE → RUN when `start`=1, with the same loads as from IDLE. `start` is ignored in RUN.
- In RUN, the next-PC source follows this priority, highest first:
  1. `halt`: state → DONE; `prog_ctr` holds.
  2. `ret` with `depth`>0: `prog_ctr` ← top entry; `depth` decrements.
  3. `ret` with `depth`=0 (underflow): `stack_err` ← 1; state → DONE; `prog_ctr` holds.
  4. `call` with `depth`<STACK_DEPTH: push `prog_ctr`+1; `depth` increments; `prog_ctr` ← jump target.
  5. `call` with `depth`=STACK_DEPTH (overflow): `stack_err` ← 1; state → DONE; no push; `prog_ctr` holds.
  6. `jmp_en`: `prog_ctr` ← jump target.
  7. Otherwise: `prog_ctr` ← `prog_ctr`+1.
- Jump target = `target` if `jmp_abs`=1, else `prog_ctr`+`target` (signed).
- All PC arithmetic is modulo 2^PC_W; wrap-around is silent. 2^PC_W−1 + 1 → 0.
- The stack is a LIFO register array indexed by `depth`. Entries above `depth` are don't-care and are not cleared.
- In IDLE and DONE, control inputs other than `start` are ignored, and `prog_ctr`, `depth`, and `stack_err` hold.
- `stack_err` stays set through DONE and clears only on an accepted `start` or on reset.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state = IDLE
  - `prog_ctr` = 0
  - `run` = 0
  - `done` = 0
  - `stack_err` = 0
  - `depth` = 0
- Reset asserted mid-RUN returns the block to IDLE immediately, with no clock required.
- Start latency: `start` is sampled at edge N; `run`=1 and `prog_ctr`=`start_addr` are visible after edge N. The first instruction executes in cycle N+1.
- Each instruction takes one cycle; a taken jump, call, or return has no bubble.
- `halt` sampled at edge N gives `run`=0 and `done`=1 after edge N. The halt instruction's own write-back is gated by the consumer using `run` from the prior cycle, not by this block.
- `start` held continuously high re-enters RUN on the edge after DONE is reached.
- A `call` and a `ret` asserted together resolve as `ret`, per the priority list.

## Test plan
- Reset, then `start`=1 with `start_addr`=0x010 → `run`=1, `prog_ctr`=0x010. With no control inputs asserted, `prog_ctr` steps 0x011, 0x012, and so on.
- At `prog_ctr`=0x020, `jmp_en`=1, `jmp_abs`=0, `target`=0x3FE (−2) → `prog_ctr`=0x01E. With `jmp_abs`=1 and `target`=0x100 → `prog_ctr`=0x100. Starting at `prog_ctr`=0x3FF with no jump → wraps to 0x000.
- At 0x030, `call` with `jmp_abs`=1, `target`=0x200 → `prog_ctr`=0x200, `depth`=1. A later `ret` → `prog_ctr`=0x031, `depth`=0.
- With STACK_DEPTH=4, five nested calls → the fifth call sets `stack_err`=1, `done`=1, `run`=0, leaves `depth`=4, and `prog_ctr` holds at the fifth call's address.
- With `depth`=0, `ret` → `stack_err`=1, `done`=1. A new `start` then clears `stack_err` and `depth`, and `run`=1.
- `halt` at 0x045 → `done`=1, `prog_ctr` stays 0x045, and `jmp_en`/`call` pulses are ignored. Asserting `reset`=0 mid-RUN → all outputs read 0 without a clock edge.
